// File: rtl/mul3_share_arbiter_pkg.sv
// Shared constants for the triple-product arbiter slice.
//   DATA_W_DEF  default operand/result width (signed two's complement)
//   SCALE_DEF   renderer fixed-point divisor applied to a*b*c
//   PROD_W_DEF  full-precision product width (3 * DATA_W_DEF)
//   prod_width  product width for an arbitrary operand width
//   id_width    requester-ID width for a given requester count
package mul3_share_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned SCALE_DEF  = 10000;
  localparam int unsigned PROD_W_DEF = 3 * DATA_W_DEF;

  function automatic int unsigned prod_width(input int unsigned dw);
    return 3 * dw;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul3_share_arbiter_mul3_pipe.sv
// Stages S2/S3 of the shared triple-product unit.
//   S2: full-precision signed product a*b*c.
//   S3: signed divide by SCALE (truncating toward zero), overflow detect,
//       registered result with valid/ID sideband.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s1_valid/s1_id   S1 sideband entering the pipe
//   s1_a/s1_b/s1_c   S1 operands
//   s2_valid         S2 occupancy (for busy)
//   rsp_valid        one-cycle result pulse (S3 occupancy)
//   rsp_id/rsp_data  result ID and low DATA_W quotient bits (held when idle)
//   rsp_ovf          quotient outside signed DATA_W range
module mul3_pipe
  import mul3_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SCALE  = SCALE_DEF,
  parameter int unsigned ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_valid,
  input  logic [ID_W-1:0]   s1_id,
  input  logic [DATA_W-1:0] s1_a,
  input  logic [DATA_W-1:0] s1_b,
  input  logic [DATA_W-1:0] s1_c,
  output logic              s2_valid,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf
);

  localparam int unsigned PROD_W = prod_width(DATA_W);
  localparam logic signed [PROD_W-1:0] DIVISOR = PROD_W'(SCALE);
  localparam logic signed [PROD_W-1:0] Q_MAX =
    $signed({{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [PROD_W-1:0] Q_MIN =
    $signed({{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  logic signed [PROD_W-1:0] ext_a, ext_b, ext_c, product;
  logic signed [PROD_W-1:0] s2_prod, quot;
  logic [ID_W-1:0]          s2_id;
  logic                     quot_ovf;

  // Operands are widened to the full product width first so the triple
  // product is exact; |a*b*c| <= 2^(3*DATA_W-3) always fits.
  always_comb begin
    ext_a   = $signed({{(PROD_W-DATA_W){s1_a[DATA_W-1]}}, s1_a});
    ext_b   = $signed({{(PROD_W-DATA_W){s1_b[DATA_W-1]}}, s1_b});
    ext_c   = $signed({{(PROD_W-DATA_W){s1_c[DATA_W-1]}}, s1_c});
    product = ext_a * ext_b * ext_c;
  end

  // Signed '/' truncates toward zero.
  always_comb begin
    quot     = s2_prod / DIVISOR;
    quot_ovf = (quot > Q_MAX) || (quot < Q_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      rsp_valid <= s2_valid;
      if (s2_valid) begin
        rsp_id   <= s2_id;
        rsp_data <= quot[DATA_W-1:0];
        rsp_ovf  <= quot_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_prod <= product;
      s2_id   <= s1_id;
    end
  end

endmodule

// File: rtl/mul3_share_arbiter.sv
// Round-robin arbiter sharing one pipelined (a*b*c)/SCALE unit among
// NUM_REQ requesters. One acceptance per cycle, fixed 3-edge latency.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en                     grant enable (pipeline drains regardless)
//   req_valid/req_ready    per-requester handshake, ready one-hot or zero
//   req_op1/req_op2/req_op3 packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_id       result pulse and requester index
//   rsp_data/rsp_ovf       low DATA_W quotient bits and range overflow
//   busy                   any pipeline stage occupied
module mul3_share_arbiter
  import mul3_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SCALE   = SCALE_DEF,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*DATA_W-1:0] req_op3,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_ovf,
  output logic                      busy
);

  logic [ID_W-1:0]   ptr, grant_id, ptr_next;
  logic              grant_any, accept;
  int unsigned       idx;
  logic              s1_valid, s2_valid;
  logic [ID_W-1:0]   s1_id;
  logic [DATA_W-1:0] s1_a, s1_b, s1_c;

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    accept    = grant_any && en && !rst;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_id <= grant_id;
      s1_a  <= req_op1[grant_id*DATA_W +: DATA_W];
      s1_b  <= req_op2[grant_id*DATA_W +: DATA_W];
      s1_c  <= req_op3[grant_id*DATA_W +: DATA_W];
    end
  end

  mul3_pipe #(
    .DATA_W (DATA_W),
    .SCALE  (SCALE),
    .ID_W   (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .s1_valid  (s1_valid),
    .s1_id     (s1_id),
    .s1_a      (s1_a),
    .s1_b      (s1_b),
    .s1_c      (s1_c),
    .s2_valid  (s2_valid),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  // rsp_valid doubles as the S3 occupancy flag.
  assign busy = s1_valid | s2_valid | rsp_valid;

endmodule
